// File: rtl/edl_sync_sink.sv
// Terminal sink of the EDL asynchronous pipeline: synchronises the 4-phase request/error handshakes
// into clk, captures {Lerr,Ldata} into a FIFO and emits a valid/ready stream. Define EDL_SINK_ERRCNT_EN for err_count.
module edl_sync_sink #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Lreq,
    output logic                     Lack,
    output logic                     LEreq,
    input  logic                     LEack,
    input  logic [WIDTH-1:0]         Ldata,
    input  logic                     Lerr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Gray-coded so that bit1 is Lack and bit0 is LEreq: both handshake outputs come straight from flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EREQ = 2'b01,
        RTZ  = 2'b11,
        ERTZ = 2'b10
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] lreq_sync, leack_sync;
    logic                   lreq_s, leack_s;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic            full, pop, push, push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lreq_sync  <= '0;
            leack_sync <= '0;
        end else begin
            lreq_sync  <= {lreq_sync[SYNC_STAGES-2:0], Lreq};
            leack_sync <= {leack_sync[SYNC_STAGES-2:0], LEack};
        end
    end

    assign lreq_s  = lreq_sync[SYNC_STAGES-1];
    assign leack_s = leack_sync[SYNC_STAGES-1];

    assign full      = (count == LW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push_ok   = !full || pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (lreq_s)   state_nx = EREQ;
            EREQ:    if (push)     state_nx = RTZ;
            RTZ:     if (!lreq_s)  state_nx = ERTZ;
            ERTZ:    if (!leack_s) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_comb begin
        push = 1'b0;
        if (state == EREQ && leack_s && push_ok) push = 1'b1;
    end

    assign Lack  = state[1];
    assign LEreq = state[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {Lerr, Ldata};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {out_err, out_data} = mem[rd_ptr];
    assign level               = count;

`ifdef EDL_SINK_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt;

    // Saturating: a wrapped count would under-report a burst of errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  err_cnt <= '0;
        else if (push && Lerr && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end

    assign err_count = err_cnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_edl_sync_sink.sv
// Self-checking bench for edl_sync_sink: emulates the upstream EDL controller and checks every cycle
// against a token-queue model, plus literal checks of latency, stall, error flags and reset.
module tb_edl_sync_sink;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int CNT_W = 3;
`ifdef EDL_SINK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0, rst = 1'b1;
    logic               Lreq = 1'b0, LEack = 1'b0, Lerr = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0]   Ldata = '0;
    logic               Lack, LEreq, out_valid, out_err;
    logic [WIDTH-1:0]   out_data;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]   err_count;

    int n_cmp = 0, n_bad = 0;
    int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random

    edl_sync_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Lreq(Lreq), .Lack(Lack), .LEreq(LEreq), .LEack(LEack),
        .Ldata(Ldata), .Lerr(Lerr), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .level(level), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the handshake phase in terms of the two output wires, a token queue and a count.
    typedef struct packed { logic err; logic [WIDTH-1:0] data; } tok_t;
    tok_t mq[$];
    bit   m_lack = 0, m_lereq = 0;
    bit   mls[SS], mes[SS];
    int   m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_lack = 0; m_lereq = 0; m_cnt = 0;
            for (int i = 0; i < SS; i++) begin mls[i] = 0; mes[i] = 0; end
        end else begin : step
            bit ls, es, pop, room;
            ls = mls[SS-1];
            es = mes[SS-1];
            for (int i = SS-1; i > 0; i--) begin mls[i] = mls[i-1]; mes[i] = mes[i-1]; end
            mls[0] = Lreq;
            mes[0] = LEack;
            pop  = (mq.size() > 0) && out_ready;
            room = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (!m_lereq && !m_lack) begin
                if (ls) m_lereq = 1;
            end else if (m_lereq && !m_lack) begin
                if (es && room) begin
                    mq.push_back({Lerr, Ldata});
                    m_lack = 1;
                    if (CNT_EN && Lerr && m_cnt < (2**CNT_W - 1)) m_cnt++;
                end
            end else if (m_lereq && m_lack) begin
                if (!ls) m_lereq = 0;
            end else begin
                if (!es) m_lack = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("Lack", Lack, m_lack);
        chk("LEreq", LEreq, m_lereq);
        chk("out_valid", out_valid, mq.size() > 0);
        chk("level", level, mq.size());
        chk("err_count", err_count, m_cnt);
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_err", out_err, mq[0].err);
        end
    end

    task automatic idle(input int c);
        repeat (c) begin @(posedge clk); #1; end
    endtask

    task automatic wait_for(input int sel, input logic val, output int n);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1; n++;
            if (((sel == 0) ? LEreq : Lack) == val) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL timeout %s waiting for %0d", (sel == 0) ? "LEreq" : "Lack", val);
    endtask

    // One full 4-phase cycle as the upstream controller; data goes stale as soon as Lack is seen.
    task automatic send(input logic [WIDTH-1:0] d, input logic e, input int gap,
                        output int l1, output int l2);
        int n;
        Ldata = d; Lerr = e; Lreq = 1'b1;
        wait_for(0, 1'b1, l1);
        idle($urandom_range(0, gap));
        LEack = 1'b1;
        wait_for(1, 1'b1, l2);
        Ldata = $urandom; Lerr = 1'($urandom_range(0, 1));
        idle($urandom_range(0, gap));
        Lreq = 1'b0;
        wait_for(0, 1'b0, n);
        idle($urandom_range(0, gap));
        LEack = 1'b0;
        wait_for(1, 1'b0, n);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rdy_mode = 1;
        @(posedge clk); #1 rdy_mode = 0;
    endtask

    initial begin #1_000_000; $display("FAIL watchdog expired"); $fatal(1); end

    initial begin
        int l1, l2, n, vc;
        logic [WIDTH-1:0] vd, d[5];
        logic ve;
        bit done5;

        idle(3);
        chk("rst Lack", Lack, 0);      chk("rst LEreq", LEreq, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0); chk("rst out_err", out_err, 0);
        chk("rst level", level, 0);    chk("rst err_count", err_count, 0);
        rst = 1'b0;
        idle(2);

        // single token with latency pinning
        rdy_mode = 1; vc = 0; vd = '0; ve = 1'b1;
        fork
            send(32'hA5A5A5A5, 1'b0, 0, l1, l2);
            repeat (40) begin
                @(posedge clk); #1;
                if (out_valid) begin vc++; vd = out_data; ve = out_err; end
            end
        join
        chk("lat Lreq->LEreq", l1, 3);
        chk("lat LEack->Lack", l2, 3);
        chk("valid cycles", vc, 1);
        chk("single data", vd, 32'hA5A5A5A5);
        chk("single err", ve, 0);
        chk("single Lack low", Lack, 0);

        // error flags 1,0,1
        rdy_mode = 0;
        send($urandom, 1'b1, 2, l1, l2);
        send($urandom, 1'b0, 2, l1, l2);
        send($urandom, 1'b1, 2, l1, l2);
        chk("err level", level, 3);
        chk("err_count 101", err_count, CNT_EN ? 2 : 0);
        chk("err seq0", out_err, 1); pop_one();
        chk("err seq1", out_err, 0); pop_one();
        chk("err seq2", out_err, 1); pop_one();
        chk("err drained", out_valid, 0);

        // five tokens into a four-deep FIFO, 5th stalls until one pop
        for (int i = 0; i < 5; i++) d[i] = $urandom;
        for (int i = 0; i < 4; i++) send(d[i], 1'b0, 1, l1, l2);
        chk("full level", level, 4);
        done5 = 0;
        fork begin send(d[4], 1'b0, 0, l1, l2); done5 = 1; end join_none
        idle(20);
        chk("stall Lack", Lack, 0);
        chk("stall LEreq", LEreq, 1);
        chk("stall level", level, 4);
        pop_one();
        for (int k = 0; k < 300 && !done5; k++) idle(1);
        chk("5th done", done5, 1);
        chk("push+pop level", level, 4);
        chk("order head", out_data, d[1]);
        rdy_mode = 1; idle(10);
        chk("drain level", level, 0);

        // reset while in RTZ with two entries
        rdy_mode = 0;
        send($urandom, 1'b0, 1, l1, l2);
        Ldata = $urandom; Lerr = 1'b1; Lreq = 1'b1;
        wait_for(0, 1'b1, n);
        LEack = 1'b1;
        wait_for(1, 1'b1, n);
        chk("pre-rst level", level, 2);
        #2 rst = 1'b1;
        #1;
        chk("midrst Lack", Lack, 0);   chk("midrst LEreq", LEreq, 0);
        chk("midrst out_valid", out_valid, 0); chk("midrst level", level, 0);
        Lreq = 1'b0; LEack = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        rdy_mode = 1;
        send(32'h1234_5678, 1'b0, 1, l1, l2);
        chk("post-rst lat1", l1, 3);
        chk("post-rst lat2", l2, 3);

        // randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) send($urandom, 1'($urandom_range(0, 1)), 4, l1, l2);
        rdy_mode = 1; idle(10);
        chk("final empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
